// File: rtl/trig_sequencer_pkg.sv
// Shared definitions for the trigger sequencer: default parameter values,
// sequencer state encoding and a small constant helper.
package trig_sequencer_pkg;

    localparam int DEF_N_CH       = 24;
    localparam int DEF_WINDOW     = 24;
    localparam int DEF_PULSE_LEN  = 3;
    localparam int DEF_HOLDOFF    = 4;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TS_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } trig_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/trig_sequencer_fifo.sv
// Synchronous first-word-fall-through event FIFO with occupancy count.
// A push on a full FIFO succeeds only when a pop frees a slot in the same cycle.
module trig_sequencer_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       empty_nxt,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        count_nxt = count_q;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + (AW+1)'(1);
            2'b01:   count_nxt = count_q - (AW+1)'(1);
            default: count_nxt = count_q;
        endcase
    end

    assign empty_nxt = (count_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_nxt;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head_data = mem[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/trig_sequencer.sv
// Trigger sequencer: coincidence window, trigger pulse, holdoff and
// timestamped event queueing for MCU readout.
module trig_sequencer
    import trig_sequencer_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int PULSE_LEN  = DEF_PULSE_LEN,
    parameter int HOLDOFF    = DEF_HOLDOFF,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TS_W       = DEF_TS_W
) (
    input  logic                          pll_clk,
    input  logic                          reset_synchronous,
    input  logic                          enable,
    input  logic [N_CH-1:0]               hit_edge,
    input  logic                          ext_trig,
    output logic                          trig_out,
    output logic                          veto_out,
    output logic                          evt_valid,
    output logic [N_CH-1:0]               evt_pattern,
    output logic [TS_W-1:0]               evt_ts,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          clear_ovf,
    output logic                          irq_n
);

    localparam int TMR_MAX = max3(WINDOW, PULSE_LEN, HOLDOFF);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int EVT_W   = N_CH + TS_W;

    trig_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [N_CH-1:0]  pattern_q, pattern_d;
    logic [TS_W-1:0]  ts_lat_q, ts_lat_d;
    logic [TS_W-1:0]  ts_q;
    logic             push;
    logic [EVT_W-1:0] push_data;
    logic [EVT_W-1:0] head_data;
    logic             fifo_empty;
    logic             fifo_empty_nxt;
    logic             fifo_drop;
    logic             trig_p1;
    logic             veto_p1;
    logic             irq_n_p1;
    logic             ovf_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        ts_lat_d  = ts_lat_q;
        push      = 1'b0;
        push_data = {pattern_q | hit_edge, ts_lat_q};
        case (state_q)
            ST_IDLE: begin
                if (enable && (|hit_edge || ext_trig)) begin
                    pattern_d = hit_edge;
                    ts_lat_d  = ts_q;
                    timer_d   = '0;
                    // An external trigger needs no window: the event is the current sample.
                    if (ext_trig) begin
                        push      = 1'b1;
                        push_data = {hit_edge, ts_q};
                        state_d   = ST_FIRE;
                    end else begin
                        state_d   = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                pattern_d = pattern_q | hit_edge;
                timer_d   = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(WINDOW - 1) || ext_trig) begin
                    push    = 1'b1;
                    timer_d = '0;
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(PULSE_LEN - 1)) begin
                    timer_d = '0;
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(HOLDOFF - 1)) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pll_clk) begin
        if (reset_synchronous) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pattern_q <= '0;
            ts_lat_q  <= '0;
            ts_q      <= '0;
            trig_p1   <= 1'b0;
            veto_p1   <= 1'b0;
            irq_n_p1  <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pattern_q <= pattern_d;
            ts_lat_q  <= ts_lat_d;
            ts_q      <= ts_q + TS_W'(1);
            trig_p1   <= (state_d == ST_FIRE);
            veto_p1   <= (state_d != ST_IDLE);
            irq_n_p1  <= fifo_empty_nxt;
            if (fifo_drop)      ovf_q <= 1'b1;
            else if (clear_ovf) ovf_q <= 1'b0;
        end
    end

    trig_sequencer_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pll_clk),
        .rst       (reset_synchronous),
        .push      (push),
        .push_data (push_data),
        .pop       (evt_pop),
        .head_data (head_data),
        .count     (evt_count),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt),
        .drop      (fifo_drop)
    );

    assign trig_out    = trig_p1;
    assign veto_out    = veto_p1;
    assign irq_n       = irq_n_p1;
    assign overflow    = ovf_q;
    assign evt_valid   = ~fifo_empty;
    assign evt_pattern = head_data[TS_W +: N_CH];
    assign evt_ts      = head_data[TS_W-1:0];

endmodule

// File: tb/tb_trig_sequencer.sv
// Bench for trig_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked against a cycle-number/queue reference model.
module tb_trig_sequencer;

    localparam int N_CH       = 24;
    localparam int WINDOW     = 24;
    localparam int PULSE_LEN  = 3;
    localparam int HOLDOFF    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int TS_W       = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                clk = 1'b0;
    logic                reset_synchronous = 1'b1;
    logic                enable = 1'b0;
    logic [N_CH-1:0]     hit_edge = '0;
    logic                ext_trig = 1'b0;
    logic                trig_out, veto_out, evt_valid, overflow, irq_n;
    logic [N_CH-1:0]     evt_pattern;
    logic [TS_W-1:0]     evt_ts;
    logic                evt_pop = 1'b0;
    logic [CW-1:0]       evt_count;
    logic                clear_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int t;

    always #5 clk = ~clk;

    trig_sequencer #(
        .N_CH(N_CH), .WINDOW(WINDOW), .PULSE_LEN(PULSE_LEN),
        .HOLDOFF(HOLDOFF), .FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)
    ) dut (
        .pll_clk(clk), .reset_synchronous(reset_synchronous), .enable(enable),
        .hit_edge(hit_edge), .ext_trig(ext_trig), .trig_out(trig_out),
        .veto_out(veto_out), .evt_valid(evt_valid), .evt_pattern(evt_pattern),
        .evt_ts(evt_ts), .evt_pop(evt_pop), .evt_count(evt_count),
        .overflow(overflow), .clear_ovf(clear_ovf), .irq_n(irq_n)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: windows and pulses as cycle-number intervals, FIFO as a queue.
    int               cyc = 0;
    bit               in_win = 0;
    int               start_c = 0;
    int               commit_c = -1000;
    int               busy_end = -1000;
    logic [N_CH-1:0]  m_pat;
    logic [TS_W-1:0]  m_tsl;
    logic [TS_W-1:0]  m_ts = '0;
    bit               m_ovf = 0;
    logic [N_CH+TS_W-1:0] mq[$];
    bit               e_trig = 0, e_veto = 0, e_ovf = 0;
    int               e_cnt = 0;
    logic [N_CH+TS_W-1:0] e_head;

    always @(posedge clk) begin
        int c;
        bit push, drop;
        logic [N_CH+TS_W-1:0] pd;
        c = cyc;
        push = 0;
        drop = 0;
        pd = '0;
        if (reset_synchronous) begin
            mq.delete();
            m_ovf = 0; m_ts = '0; in_win = 0;
            commit_c = -1000; busy_end = -1000;
        end else begin
            if (in_win) begin
                m_pat = m_pat | hit_edge;
                if (c == start_c + WINDOW || ext_trig) begin
                    push = 1; pd = {m_pat, m_tsl};
                    commit_c = c; busy_end = c + PULSE_LEN + HOLDOFF; in_win = 0;
                end
            end else if (c > busy_end && enable && (|hit_edge || ext_trig)) begin
                start_c = c; m_pat = hit_edge; m_tsl = m_ts;
                if (ext_trig) begin
                    push = 1; pd = {hit_edge, m_ts};
                    commit_c = c; busy_end = c + PULSE_LEN + HOLDOFF;
                end else begin
                    in_win = 1;
                end
            end
            if (evt_pop && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(pd);
                else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (clear_ovf) m_ovf = 0;
            m_ts = m_ts + 1'b1;
        end
        e_trig = (c + 1 > commit_c) && (c + 1 <= commit_c + PULSE_LEN);
        e_veto = in_win || (c + 1 <= busy_end);
        e_ovf  = m_ovf;
        e_cnt  = mq.size();
        e_head = (mq.size() > 0) ? mq[0] : '0;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("trig_out", trig_out, e_trig);
            check("veto_out", veto_out, e_veto);
            check("evt_count", evt_count, e_cnt);
            check("evt_valid", evt_valid, e_cnt != 0);
            check("irq_n", irq_n, e_cnt == 0);
            check("overflow", overflow, e_ovf);
            if (e_cnt != 0) begin
                check("evt_pattern", evt_pattern, e_head[TS_W +: N_CH]);
                check("evt_ts", evt_ts, e_head[TS_W-1:0]);
            end
        end
    end

    task automatic adv();
        @(negedge clk);
        t++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_trig", trig_out, 0);
        check("rst_veto", veto_out, 0);
        check("rst_irq_n", irq_n, 1);
        check("rst_count", evt_count, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_ovf", overflow, 0);

        // single hit on ch3, timestamp 0 right after reset
        reset_synchronous = 0; enable = 1; t = 0;
        hit_edge = 24'h000008;
        adv(); hit_edge = '0;
        check("t1_veto1", veto_out, 1);
        repeat (23) adv();
        check("t1_trig24", trig_out, 0);
        check("t1_irq24", irq_n, 1);
        adv();
        check("t1_trig25", trig_out, 1);
        check("t1_irq25", irq_n, 0);
        check("t1_pat", evt_pattern, 24'h000008);
        check("t1_ts", evt_ts, 0);
        adv(); adv();
        check("t1_trig27", trig_out, 1);
        adv();
        check("t1_trig28", trig_out, 0);
        repeat (3) adv();
        check("t1_veto31", veto_out, 1);
        adv();
        check("t1_veto32", veto_out, 0);
        evt_pop = 1; adv(); evt_pop = 0;
        check("t1_popcnt", evt_count, 0);

        // ch0 at 0, ch5 at the last window cycle, ch7 while firing
        t = 0; hit_edge = 24'h000001;
        adv(); hit_edge = '0;
        repeat (23) adv();
        hit_edge = 24'h000020; adv();
        hit_edge = 24'h000080; adv();
        hit_edge = '0;
        check("t2_pat", evt_pattern, 24'h000021);
        repeat (8) adv();
        check("t2_count", evt_count, 1);
        evt_pop = 1; adv(); evt_pop = 0;

        // ext_trig cuts the window short
        t = 0; hit_edge = 24'h000002;
        adv(); hit_edge = '0;
        repeat (9) adv();
        check("t3_trig10", trig_out, 0);
        ext_trig = 1; adv(); ext_trig = 0;
        check("t3_trig11", trig_out, 1);
        check("t3_pat", evt_pattern, 24'h000002);
        adv(); adv();
        check("t3_trig13", trig_out, 1);
        adv();
        check("t3_trig14", trig_out, 0);
        repeat (4) adv();
        evt_pop = 1; adv(); evt_pop = 0;

        // fill the FIFO, then overflow, clear, and push+pop at full
        t = 0; hit_edge = 24'h000004;
        adv(); hit_edge = '0;
        repeat (31) adv();
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            ext_trig = 1; adv(); ext_trig = 0;
            repeat (7) adv();
        end
        check("t4_full", evt_count, 16);
        check("t4_noovf", overflow, 0);
        ext_trig = 1; adv(); ext_trig = 0;
        check("t4_ovf", overflow, 1);
        check("t4_count", evt_count, 16);
        check("t4_trig", trig_out, 1);
        check("t4_head", evt_pattern, 24'h000004);
        repeat (7) adv();
        clear_ovf = 1; adv(); clear_ovf = 0;
        check("t4_clr", overflow, 0);
        ext_trig = 1; evt_pop = 1; adv(); ext_trig = 0; evt_pop = 0;
        check("t4_pp_cnt", evt_count, 16);
        check("t4_pp_ovf", overflow, 0);
        check("t4_pp_head", evt_pattern, 24'h000000);
        repeat (7) adv();
        evt_pop = 1; repeat (17) adv(); evt_pop = 0;
        check("t4_drain", evt_count, 0);

        // reset in the middle of a window
        t = 0; hit_edge = 24'h000200;
        adv(); hit_edge = '0;
        repeat (11) adv();
        reset_synchronous = 1; adv(); reset_synchronous = 0;
        check("t5_trig", trig_out, 0);
        check("t5_veto", veto_out, 0);
        check("t5_irq", irq_n, 1);
        repeat (30) adv();
        check("t5_count", evt_count, 0);

        // enable low ignores hits; enable dropped mid-window does not abort
        enable = 0; hit_edge = 24'h000010;
        repeat (3) adv(); hit_edge = '0;
        adv();
        check("t6_veto", veto_out, 0);
        check("t6_count", evt_count, 0);
        enable = 1; t = 0; hit_edge = 24'h000040;
        adv(); hit_edge = '0;
        repeat (4) adv(); enable = 0;
        repeat (20) adv();
        check("t6_trig25", trig_out, 1);
        check("t6_pat", evt_pattern, 24'h000040);
        repeat (7) adv();
        enable = 1; evt_pop = 1; adv(); evt_pop = 0;

        // randomized traffic; first half drains slowly so the FIFO saturates
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      hit_edge = N_CH'(1) << $urandom_range(0, N_CH - 1);
            else if (r == 1) hit_edge = N_CH'($urandom);
            else             hit_edge = '0;
            ext_trig  = (hit_edge == '0) && ($urandom_range(0, 40) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            evt_pop   = (i < 2000) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 2) == 0);
            clear_ovf = ($urandom_range(0, 49) == 0);
            reset_synchronous = ($urandom_range(0, 1199) == 0);
            adv();
        end
        reset_synchronous = 0; hit_edge = '0; ext_trig = 0; evt_pop = 0; clear_ovf = 0;
        repeat (40) adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
